// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port-B arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int RD_LAT = 2;

endpackage

// File: rtl/mem_arb_rtag.sv
// Read-return tag pipeline: a {valid, id} shift register, RD_LAT stages deep,
// whose last stage selects which requester sees the load data strobe.
module mem_arb_rtag
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push_valid,
  input  logic push_id,
  output logic m0_rvalid,
  output logic m1_rvalid
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] id_q, id_d;

  always_comb begin
    vld_d = {vld_q[RD_LAT-2:0], push_valid};
    id_d  = {id_q[RD_LAT-2:0], push_id};
  end

  // Reset drops in-flight tags so no load issued before it ever returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= {RD_LAT{1'b0}};
      id_q  <= {RD_LAT{1'b0}};
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign m0_rvalid = vld_q[RD_LAT-1] & (id_q[RD_LAT-1] == REQ_CPU);
  assign m1_rvalid = vld_q[RD_LAT-1] & (id_q[RD_LAT-1] == REQ_HOST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for RAM port B with bounded bursts and fixed-latency reads.
// MEM_ARB_RR_EN selects round robin with burst limit on both owners; default is m0 priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

`ifdef MEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  arb_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;

  logic pol_vld_s, pol_id_s;
  logic win_vld_s, win_id_s;
  logic same_own_s, sel_we_s;

  // Free arbitration, used from IDLE or when the current owner lets go.
  always_comb begin
    pol_vld_s = m0_req | m1_req;
    if (m0_req && m1_req) begin
      pol_id_s = RR_EN ? ~last_q : REQ_CPU;
    end else if (m1_req) begin
      pol_id_s = REQ_HOST;
    end else begin
      pol_id_s = REQ_CPU;
    end
  end

  always_comb begin
    win_vld_s = pol_vld_s;
    win_id_s  = pol_id_s;
    case (state_q)
      ARB_OWN0: begin
        if (m0_req) begin
          win_vld_s = 1'b1;
          win_id_s  = (RR_EN && m1_req && (cnt_q == BURST_LIM)) ? REQ_HOST : REQ_CPU;
        end else begin
          win_vld_s = pol_vld_s;
          win_id_s  = pol_id_s;
        end
      end
      ARB_OWN1: begin
        if (m1_req) begin
          win_vld_s = 1'b1;
          win_id_s  = (m0_req && (cnt_q == BURST_LIM)) ? REQ_CPU : REQ_HOST;
        end else begin
          win_vld_s = pol_vld_s;
          win_id_s  = pol_id_s;
        end
      end
      default: begin
        win_vld_s = pol_vld_s;
        win_id_s  = pol_id_s;
      end
    endcase
  end

  assign m0_gnt = ~reset & win_vld_s & (win_id_s == REQ_CPU);
  assign m1_gnt = ~reset & win_vld_s & (win_id_s == REQ_HOST);

  assign same_own_s = ((state_q == ARB_OWN0) && (win_id_s == REQ_CPU)) ||
                      ((state_q == ARB_OWN1) && (win_id_s == REQ_HOST));
  assign sel_we_s   = (win_id_s == REQ_HOST) ? m1_we : m0_we;

  // Without an accept the RAM address and data hold; only the write enable drops.
  always_comb begin
    state_d    = ARB_IDLE;
    cnt_d      = 4'd0;
    last_d     = last_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    if (win_vld_s) begin
      state_d    = (win_id_s == REQ_HOST) ? ARB_OWN1 : ARB_OWN0;
      cnt_d      = !same_own_s ? 4'd1 :
                   (cnt_q == BURST_LIM) ? cnt_q : cnt_q + 4'd1;
      last_d     = win_id_s;
      ram_addr_d = (win_id_s == REQ_HOST) ? m1_addr : m0_addr;
      ram_din_d  = (win_id_s == REQ_HOST) ? m1_wdata : m0_wdata;
      ram_we_d   = sel_we_s;
    end else begin
      state_d = ARB_IDLE;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= 4'd0;
      last_q     <= REQ_HOST;
      ram_addr_q <= {ADDR_W{1'b0}};
      ram_din_q  <= {DATA_W{1'b0}};
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
    end
  end

  mem_arb_rtag u_rtag (
    .clk       (clk),
    .reset     (reset),
    .push_valid(win_vld_s & ~sel_we_s),
    .push_id   (win_id_s),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid)
  );

  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;
  assign m0_rdata = ram_dout;
  assign m1_rdata = ram_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MAX_BURST=4 on a RAM model,
// a second with MAX_BURST=1 sharing the request inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata, ram_addr, ram_din, ram_dout;
  logic        ram_we;

  logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_ram_we;
  logic [15:0] b_m0_rdata, b_m1_rdata, b_ram_addr, b_ram_din;
  logic [15:0] zero_dout = 16'h0000;

  logic        pl_we;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(b_m0_gnt), .m1_gnt(b_m1_gnt), .m0_rvalid(b_m0_rvalid), .m1_rvalid(b_m1_rvalid),
    .m0_rdata(b_m0_rdata), .m1_rdata(b_m1_rdata),
    .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_we(b_ram_we), .ram_dout(zero_dout)
  );

  // Synchronous write-first RAM with a bench-side preload port.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[9:0]] <= ram_din;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end
    ram_dout <= ram_we ? ram_din : mem[ram_addr[9:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r0, input logic we0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic we1, input logic [15:0] a1, input logic [15:0] d1);
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
  endtask

  logic [12:0] r0_v, r1_v, e0_v, e1_v, f0_v, f1_v;
  logic        r0_b, r1_b, x0_b, x1_b;

  initial begin
    reset = 1'b1;
    pl_we = 1'b0; pl_addr = 10'd0; pl_data = 16'h0000;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = 10'h010; pl_data = 16'h1234;
    tick();
    pl_addr = 10'h020; pl_data = 16'h5678;
    tick();
    pl_addr = 10'h200; pl_data = 16'h0000;
    tick();
    pl_we = 1'b0;

    // reset state, including gnt held low against a live request
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000);
    #1;
    check_eq("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    check_eq("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rst_ram_din", 32'(ram_din), 32'h0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b0;
    tick();

    // single m0 load of 0x0010
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check_eq("ld_m0_gnt", 32'(m0_gnt), 32'd1);
    check_eq("ld_m1_gnt", 32'(m1_gnt), 32'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check_eq("ld_ram_addr", 32'(ram_addr), 32'h0010);
    check_eq("ld_ram_we", 32'(ram_we), 32'd0);
    check_eq("ld_rvalid_early", 32'(m0_rvalid), 32'd0);
    tick();
    check_eq("ld_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check_eq("ld_m0_rdata", 32'(m0_rdata), 32'h1234);
    check_eq("ld_m1_rvalid", 32'(m1_rvalid), 32'd0);
    tick();
    check_eq("ld_rvalid_pulse", 32'(m0_rvalid), 32'd0);

    // m1 store then m0 load of the same address
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'hBEEF);
    #1;
    check_eq("st_m1_gnt", 32'(m1_gnt), 32'd1);
    tick();
    drive(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check_eq("st_m0_gnt", 32'(m0_gnt), 32'd1);
    check_eq("st_ram_we", 32'(ram_we), 32'd1);
    check_eq("st_ram_addr", 32'(ram_addr), 32'h0200);
    check_eq("st_ram_din", 32'(ram_din), 32'hBEEF);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check_eq("st_ram_we_drop", 32'(ram_we), 32'd0);
    check_eq("st_no_m1_rvalid", 32'(m1_rvalid), 32'd0);
    tick();
    check_eq("st_ld_rvalid", 32'(m0_rvalid), 32'd1);
    check_eq("st_ld_rdata", 32'(m0_rdata), 32'hBEEF);
    check_eq("st_ram_addr_hold", 32'(ram_addr), 32'h0200);
    tick();

    // load accepted, then reset: the return must be flushed
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check_eq("fl_m0_gnt", 32'(m0_gnt), 32'd1);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    reset = 1'b0;
    check_eq("fl_rvalid_a", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    check_eq("fl_ram_we", 32'(ram_we), 32'd0);
    check_eq("fl_ram_addr", 32'(ram_addr), 32'h0);
    tick();
    check_eq("fl_rvalid_b", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    tick();

    // contention, bit i = cycle i; e* for MAX_BURST=4, f* for MAX_BURST=1
`ifdef MEM_ARB_RR_EN
    r0_v = 13'b1111111111111; r1_v = 13'b1111111111111;
    e0_v = 13'b0111100001111; e1_v = 13'b1000011110000;
    f0_v = 13'b1010101010101; f1_v = 13'b0101010101010;
`else
    r0_v = 13'b1110011111111; r1_v = 13'b1111111111111;
    e0_v = 13'b1000011111111; e1_v = 13'b0111100000000;
    f0_v = 13'b1110011111111; f1_v = 13'b0001100000000;
`endif
    for (int i = 0; i < 15; i++) begin
      r0_b = (i < 13) ? r0_v[i] : 1'b0;
      r1_b = (i < 13) ? r1_v[i] : 1'b0;
      drive(r0_b, 1'b0, 16'h0010, 16'h0000, r1_b, 1'b0, 16'h0020, 16'h0000);
      #1;
      check_eq($sformatf("ct_m0_gnt[%0d]", i), 32'(m0_gnt), (i < 13) ? 32'(e0_v[i]) : 32'd0);
      check_eq($sformatf("ct_m1_gnt[%0d]", i), 32'(m1_gnt), (i < 13) ? 32'(e1_v[i]) : 32'd0);
      check_eq($sformatf("b1_m0_gnt[%0d]", i), 32'(b_m0_gnt), (i < 13) ? 32'(f0_v[i]) : 32'd0);
      check_eq($sformatf("b1_m1_gnt[%0d]", i), 32'(b_m1_gnt), (i < 13) ? 32'(f1_v[i]) : 32'd0);
      if (i >= 2) begin
        x0_b = e0_v[i-2];
        x1_b = e1_v[i-2];
        check_eq($sformatf("ct_rvalid[%0d]", i), {30'd0, m1_rvalid, m0_rvalid}, {30'd0, x1_b, x0_b});
        check_eq($sformatf("ct_rdata[%0d]", i), 32'(m0_rdata), x0_b ? 32'h1234 : 32'h5678);
        check_eq($sformatf("b1_rvalid[%0d]", i), {30'd0, b_m1_rvalid, b_m0_rvalid},
                 {30'd0, f1_v[i-2], f0_v[i-2]});
      end else begin
        check_eq($sformatf("ct_rvalid[%0d]", i), {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check_eq($sformatf("b1_rvalid[%0d]", i), {30'd0, b_m1_rvalid, b_m0_rvalid}, 32'd0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
